// File: rtl/mult_share_pkg.sv
// Shared constants and product scaling for the OMP multiplier arbiter.
// Define MULT_SAT_EN to saturate out-of-range products instead of wrapping.
package mult_share_pkg;

    localparam int DW        = 16;
    localparam int N_REQ_DEF = 4;

    localparam logic [DW-1:0] SAT_MAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0] SAT_MIN = {1'b1, {(DW-1){1'b0}}};

    // Drops frac LSBs (arithmetic, toward -inf) and keeps DW bits of the result.
    function automatic logic [DW-1:0] sat_scale(input logic signed [2*DW-1:0] product,
                                                input int frac);
        logic signed [2*DW-1:0] shifted;
        shifted = product >>> frac;
`ifdef MULT_SAT_EN
        if (shifted[2*DW-1:DW-1] != {(DW+1){shifted[DW-1]}})
            return product[2*DW-1] ? SAT_MIN : SAT_MAX;
        return shifted[DW-1:0];
`else
        return DW'(shifted);
`endif
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first request at or
// above ptr, wrapping to the lowest index.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant
);

    logic found;

    // First pass covers indices at or above ptr, second pass the wrapped part.
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found && req[i] && (i >= int'(ptr))) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!found && req[i]) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mult_share_arb.sv
// One signed DW x DW multiplier shared by N_REQ requesters through a round-robin
// arbiter and a 2-stage pipeline; MULT_SAT_EN selects saturation over wrap.
module mult_share_arb #(
    parameter int N_REQ     = mult_share_pkg::N_REQ_DEF,
    parameter int DW        = mult_share_pkg::DW,
    parameter int FRAC_BITS = 0,
    parameter int IDW       = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_REQ-1:0]    req_valid,
    output logic [N_REQ-1:0]    req_ready,
    input  logic [N_REQ*DW-1:0] req_a,
    input  logic [N_REQ*DW-1:0] req_b,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [IDW-1:0]      rsp_id,
    output logic [DW-1:0]       rsp_p
);

    import mult_share_pkg::*;

    logic                   adv1, adv2;
    logic                   accept;
    logic [N_REQ-1:0]       grant;
    logic [IDW-1:0]         ptr;
    logic [IDW-1:0]         gidx;
    logic [DW-1:0]          a_sel, b_sel;
    logic                   s1_v;
    logic signed [DW-1:0]   a_r, b_r;
    logic [IDW-1:0]         id_r;
    logic signed [2*DW-1:0] prod;

    assign adv2 = !rsp_valid || rsp_ready;
    assign adv1 = !s1_v || adv2;

    rr_arbiter #(.N(N_REQ), .PW(IDW)) u_arb (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (grant)
    );

    // grant is only ever set for a valid request, so any ready bit is an accept.
    assign req_ready = grant & {N_REQ{adv1}};
    assign accept    = |req_ready;

    always_comb begin
        gidx  = '0;
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                gidx  = IDW'(i);
                a_sel = req_a[i*DW +: DW];
                b_sel = req_b[i*DW +: DW];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ptr <= '0;
        else if (accept)
            ptr <= (gidx == IDW'(N_REQ-1)) ? '0 : gidx + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v <= 1'b0;
            a_r  <= '0;
            b_r  <= '0;
            id_r <= '0;
        end else if (adv1) begin
            s1_v <= accept;
            if (accept) begin
                a_r  <= a_sel;
                b_r  <= b_sel;
                id_r <= gidx;
            end
        end
    end

    assign prod = a_r * b_r;

    // rsp_* only change on advance, so they hold steady while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_p     <= '0;
        end else if (adv2) begin
            rsp_valid <= s1_v;
            if (s1_v) begin
                rsp_p  <= sat_scale(prod, FRAC_BITS);
                rsp_id <= id_r;
            end
        end
    end

endmodule

// File: tb/tb_mult_share_arb.sv
// Directed bench for mult_share_arb: a 4-requester integer instance and a
// 2-requester Q8 instance; expectations follow MULT_SAT_EN when it is defined.
module tb_mult_share_arb;

    typedef struct packed {
        logic        dut;
        logic [2:0]  id;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp_wrap;
        logic [15:0] exp_sat;
    } vec_t;

    logic        clk;
    logic        rst_n;

    logic [3:0]  req_valid0, req_ready0;
    logic [63:0] req_a0, req_b0;
    logic        rsp_valid0, rsp_ready0;
    logic [1:0]  rsp_id0;
    logic [15:0] rsp_p0;

    logic [1:0]  req_valid1, req_ready1;
    logic [31:0] req_a1, req_b1;
    logic        rsp_valid1, rsp_ready1;
    logic [0:0]  rsp_id1;
    logic [15:0] rsp_p1;

    int tests;
    int fails;

    vec_t vecs [12];

    mult_share_arb #(.N_REQ(4), .FRAC_BITS(0)) dut0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid0),
        .req_ready (req_ready0),
        .req_a     (req_a0),
        .req_b     (req_b0),
        .rsp_valid (rsp_valid0),
        .rsp_ready (rsp_ready0),
        .rsp_id    (rsp_id0),
        .rsp_p     (rsp_p0)
    );

    mult_share_arb #(.N_REQ(2), .FRAC_BITS(8)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid1),
        .req_ready (req_ready1),
        .req_a     (req_a1),
        .req_b     (req_b1),
        .rsp_valid (rsp_valid1),
        .rsp_ready (rsp_ready1),
        .rsp_id    (rsp_id1),
        .rsp_p     (rsp_p1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // One isolated request: accept, check the empty cycle, then the response.
    task automatic apply_stimulus(input vec_t v, input int n);
        int          waited;
        logic        got_ready;
        logic [15:0] exp;
`ifdef MULT_SAT_EN
        exp = v.exp_sat;
`else
        exp = v.exp_wrap;
`endif
        waited = 0;
        if (v.dut == 1'b0) begin
            req_a0[v.id*16 +: 16] = v.a;
            req_b0[v.id*16 +: 16] = v.b;
            req_valid0 = 4'b0001 << v.id;
        end else begin
            req_a1[v.id*16 +: 16] = v.a;
            req_b1[v.id*16 +: 16] = v.b;
            req_valid1 = 2'b01 << v.id;
        end
        #1;
        got_ready = (v.dut == 1'b0) ? req_ready0[v.id] : req_ready1[v.id];
        while (!got_ready && waited < 8) begin
            @(posedge clk);
            #1;
            waited++;
            got_ready = (v.dut == 1'b0) ? req_ready0[v.id] : req_ready1[v.id];
        end
        check_output($sformatf("vec%0d_accept", n), 32'(got_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid0 = '0;
        req_valid1 = '0;
        if (v.dut == 1'b0) begin
            check_output($sformatf("vec%0d_lat1_valid", n), 32'(rsp_valid0), 32'd0);
            @(posedge clk);
            #1;
            check_output($sformatf("vec%0d_valid", n), 32'(rsp_valid0), 32'd1);
            check_output($sformatf("vec%0d_id", n), 32'(rsp_id0), 32'(v.id));
            check_output($sformatf("vec%0d_p", n), 32'(rsp_p0), 32'(exp));
        end else begin
            check_output($sformatf("vec%0d_lat1_valid", n), 32'(rsp_valid1), 32'd0);
            @(posedge clk);
            #1;
            check_output($sformatf("vec%0d_valid", n), 32'(rsp_valid1), 32'd1);
            check_output($sformatf("vec%0d_id", n), 32'(rsp_id1), 32'(v.id));
            check_output($sformatf("vec%0d_p", n), 32'(rsp_p1), 32'(exp));
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests = 0;
        fails = 0;

        //                dut   id    a         b         wrap      sat
        vecs[0]  = '{1'b0, 3'd2, 16'h0003, 16'h0005, 16'h000F, 16'h000F};
        vecs[1]  = '{1'b0, 3'd1, 16'hFFFC, 16'h0007, 16'hFFE4, 16'hFFE4};
        vecs[2]  = '{1'b0, 3'd0, 16'h012C, 16'h012C, 16'h5F90, 16'h7FFF};
        vecs[3]  = '{1'b0, 3'd3, 16'hFED4, 16'h012C, 16'hA070, 16'h8000};
        vecs[4]  = '{1'b0, 3'd1, 16'h7FFF, 16'h7FFF, 16'h0001, 16'h7FFF};
        vecs[5]  = '{1'b0, 3'd0, 16'h8000, 16'hFFFF, 16'h8000, 16'h7FFF};
        vecs[6]  = '{1'b0, 3'd3, 16'h0000, 16'h1234, 16'h0000, 16'h0000};
        vecs[7]  = '{1'b0, 3'd2, 16'hFFFF, 16'hFFFF, 16'h0001, 16'h0001};
        vecs[8]  = '{1'b1, 3'd1, 16'h0180, 16'hFF00, 16'hFE80, 16'hFE80};
        vecs[9]  = '{1'b1, 3'd0, 16'h0200, 16'h0080, 16'h0100, 16'h0100};
        vecs[10] = '{1'b1, 3'd1, 16'h8000, 16'h8000, 16'h0000, 16'h7FFF};
        vecs[11] = '{1'b1, 3'd0, 16'hFF80, 16'h0001, 16'hFFFF, 16'hFFFF};

        rst_n      = 1'b0;
        req_valid0 = '0;
        req_a0     = '0;
        req_b0     = '0;
        rsp_ready0 = 1'b1;
        req_valid1 = '0;
        req_a1     = '0;
        req_b1     = '0;
        rsp_ready1 = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        check_output("reset_rsp_valid", 32'(rsp_valid0), 32'd0);
        check_output("reset_rsp_id", 32'(rsp_id0), 32'd0);
        check_output("reset_rsp_p", 32'(rsp_p0), 32'd0);
        check_output("reset_req_ready", 32'(req_ready0), 32'd0);
        check_output("reset_rsp_valid_q8", 32'(rsp_valid1), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 12; i++)
            apply_stimulus(vecs[i], i);

        // Reset with both stages full; ptr is 3 beforehand so a stale pointer shows up.
        rsp_ready0 = 1'b0;
        req_a0[48 +: 16] = 16'd9;
        req_b0[48 +: 16] = 16'd9;
        req_valid0 = 4'b1000;
        #1;
        check_output("rst_fill_grant3", 32'(req_ready0), 32'h8);
        @(posedge clk);
        #1;
        req_a0[32 +: 16] = 16'd1;
        req_b0[32 +: 16] = 16'd2;
        req_valid0 = 4'b0100;
        #1;
        check_output("rst_fill_grant2", 32'(req_ready0), 32'h4);
        @(posedge clk);
        #1;
        req_valid0 = '0;
        check_output("rst_full_valid", 32'(rsp_valid0), 32'd1);
        check_output("rst_full_id", 32'(rsp_id0), 32'd3);
        check_output("rst_full_p", 32'(rsp_p0), 32'd81);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("rst_async_valid", 32'(rsp_valid0), 32'd0);
        check_output("rst_async_id", 32'(rsp_id0), 32'd0);
        check_output("rst_async_p", 32'(rsp_p0), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n      = 1'b1;
        rsp_ready0 = 1'b1;
        @(posedge clk);
        #1;
        check_output("rst_no_stale", 32'(rsp_valid0), 32'd0);
        req_a0[16 +: 16] = 16'd6;
        req_b0[16 +: 16] = 16'd7;
        req_valid0 = 4'b1010;
        #1;
        check_output("rst_ptr_zero_grant", 32'(req_ready0), 32'h2);
        @(posedge clk);
        #1;
        req_valid0 = '0;
        check_output("rst_post_lat1", 32'(rsp_valid0), 32'd0);
        @(posedge clk);
        #1;
        check_output("rst_post_valid", 32'(rsp_valid0), 32'd1);
        check_output("rst_post_id", 32'(rsp_id0), 32'd1);
        check_output("rst_post_p", 32'(rsp_p0), 32'd42);
        @(posedge clk);
        #1;

        // Fairness: all requesters held valid from ptr = 0.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            req_a0[i*16 +: 16] = 16'(i + 1);
            req_b0[i*16 +: 16] = 16'd10;
        end
        req_valid0 = 4'b1111;
        for (int c = 0; c < 9; c++) begin
            if (c == 6)
                req_valid0 = '0;
            #1;
            if (c < 6)
                check_output($sformatf("rr_grant_c%0d", c), 32'(req_ready0), 32'(4'b0001 << (c % 4)));
            if (c >= 2 && c < 8) begin
                check_output($sformatf("rr_valid_c%0d", c), 32'(rsp_valid0), 32'd1);
                check_output($sformatf("rr_id_c%0d", c), 32'(rsp_id0), 32'((c - 2) % 4));
                check_output($sformatf("rr_p_c%0d", c), 32'(rsp_p0), 32'((((c - 2) % 4) + 1) * 10));
            end
            if (c == 8)
                check_output("rr_drained", 32'(rsp_valid0), 32'd0);
            @(posedge clk);
            #1;
        end

        // Backpressure: two accepts with rsp_ready low fill both stages (ptr is 2 here).
        rsp_ready0 = 1'b0;
        req_a0[0 +: 16]  = 16'd7;
        req_b0[0 +: 16]  = 16'd3;
        req_a0[16 +: 16] = 16'hFFFB;
        req_b0[16 +: 16] = 16'd4;
        req_valid0 = 4'b0011;
        #1;
        check_output("bp_grant0", 32'(req_ready0), 32'h1);
        @(posedge clk);
        #1;
        req_valid0 = 4'b0010;
        #1;
        check_output("bp_grant1", 32'(req_ready0), 32'h2);
        @(posedge clk);
        #1;
        req_a0[0 +: 16] = 16'd2;
        req_b0[0 +: 16] = 16'd2;
        req_valid0 = 4'b0001;
        for (int c = 0; c < 3; c++) begin
            #1;
            check_output($sformatf("bp_stall_ready_c%0d", c), 32'(req_ready0), 32'd0);
            check_output($sformatf("bp_stall_valid_c%0d", c), 32'(rsp_valid0), 32'd1);
            check_output($sformatf("bp_stall_id_c%0d", c), 32'(rsp_id0), 32'd0);
            check_output($sformatf("bp_stall_p_c%0d", c), 32'(rsp_p0), 32'd21);
            @(posedge clk);
            #1;
        end
        rsp_ready0 = 1'b1;
        #1;
        check_output("bp_release_grant", 32'(req_ready0), 32'h1);
        @(posedge clk);
        #1;
        req_valid0 = '0;
        check_output("bp_drain1_valid", 32'(rsp_valid0), 32'd1);
        check_output("bp_drain1_id", 32'(rsp_id0), 32'd1);
        check_output("bp_drain1_p", 32'(rsp_p0), 32'hFFEC);
        @(posedge clk);
        #1;
        check_output("bp_drain2_valid", 32'(rsp_valid0), 32'd1);
        check_output("bp_drain2_id", 32'(rsp_id0), 32'd0);
        check_output("bp_drain2_p", 32'(rsp_p0), 32'd4);
        @(posedge clk);
        #1;
        check_output("bp_empty", 32'(rsp_valid0), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mult_share_arb.md
Name: mult_share_arb

Overview:
- Shares one 16-bit signed fixed-point multiplier among N requesters in the OMP datapath, e.g. the correlation, projection and residual-update engines.
- Each requester has a valid/ready request channel.
- A round-robin arbiter grants one request per cycle into a 2-stage registered pipeline.
- Products return on one shared response channel, tagged with the requester ID, with backpressure.

Parameters:
N_REQ, 4, number of requesters (2..8)
DW, 16, operand and result width
FRAC_BITS, 0, fractional bits dropped from the 2*DW product (0..DW-1)
IDW, 2, ID width, equal to clog2(N_REQ)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset; asynchronous assert, active-low
req_valid  in  N_REQ  per-requester request valid
req_ready  out  N_REQ  per-requester accept
req_a  in  N_REQ*DW  operand A, requester i at [i*DW +: DW], signed
req_b  in  N_REQ*DW  operand B, same packing, signed
rsp_valid  out  1  result valid
rsp_ready  in  1  consumer accepts result
rsp_id  out  IDW  index of the requester that owns the result
rsp_p  out  DW  scaled product, signed

Behaviour:
- Reset (rst_n=0, any time): all pipeline valids, rsp_valid, rsp_id and rsp_p go to 0; round-robin pointer goes to 0. Any in-flight operations are discarded, with no response.
- Stage 1 (S1) register holds a_r, b_r, id_r and s1_v. Stage 2 (S2) register holds p_r, id, s2_v. S2 drives rsp_*.
- Stall rules:
  - adv2 = !s2_v | rsp_ready
  - adv1 = !s1_v | adv2
- Grant:
  - Round-robin over req_valid, searching from pointer ptr upward with wrap.
  - grant is one-hot or zero and combinational from req_valid and ptr.
  - req_ready[i] = grant[i] & adv1. req_ready never depends on req_ready; requesters must not drop valid or change operands until ready.
- Accept: on a clock edge with req_valid[g] & req_ready[g]:
  - S1 loads the operands of g; s1_v=1.
  - ptr becomes (g+1) mod N_REQ.
  - If there is no accept, ptr holds.
- S1 to S2, on a clock edge with adv2:
  - s2_v <= s1_v & adv1 path as above; S1 clears if nothing new is accepted.
  - p_r <= f(a_r*b_r).
- Arithmetic:
  - Full signed product, 2*DW bits.
  - Result = product[FRAC_BITS+DW-1 : FRAC_BITS]: arithmetic truncation toward -inf, wrap on overflow (see the Optional Feature).
- Latency: 2 cycles from the accept edge to rsp_valid, with no stall. Throughput is 1 result per cycle when rsp_ready=1.
- Stall: with rsp_ready=0 and S1 and S2 both full, all req_ready=0. The pipeline holds, and rsp_* stay stable while rsp_valid=1.
- Simultaneous rsp handshake and accept in the same cycle: both take effect, with no bubble.
- No request is starved: the worst-case wait is N_REQ-1 grants.

Optional Feature:
- MULT_SAT_EN defined: if the product bits above FRAC_BITS+DW-1 are not a sign-extension of bit FRAC_BITS+DW-1, the result saturates:
  - to 2^(DW-1)-1 when the product is positive;
  - to -2^(DW-1) when it is negative.
- MULT_SAT_EN undefined: plain wrap.
- Latency is the same either way.

Decomposition:
- Package mult_share_pkg holds DW, the default N_REQ, SAT_MAX/SAT_MIN constants, and the function sat_scale(product, frac) used by both the RTL and the bench model.
- Sub-module rr_arbiter (parameter N): inputs req, ptr; output one-hot grant. It is purely combinational and reusable by other shared resources.
- ptr update stays in mult_share_arb.

Test Plan:
- Single request: N_REQ=4, req 2 issues a=3, b=5, rsp_ready=1 -> rsp_valid 2 cycles after accept, rsp_id=2, rsp_p=15.
- Sign: a=0xFFFC (-4), b=7 -> rsp_p=0xFFE4 (-28). With FRAC_BITS=8, a=0x0180 (1.5), b=0xFF00 (-1.0) -> 0xFE80 (-1.5).
- Overflow: a=300, b=300 -> 0x5F90 without MULT_SAT_EN; 0x7FFF with it. a=-300, b=300 with MULT_SAT_EN -> 0x8000.
- Fairness: all 4 req_valid held high, rsp_ready=1, ptr=0 -> accepts in order 0,1,2,3,0,1 on consecutive cycles; rsp_id follows the same order 2 cycles later.
- Backpressure: rsp_ready=0 after two accepts -> req_ready=0 on all requesters; rsp_valid/rsp_id/rsp_p stable. When rsp_ready=1, the held results drain in order with no loss or duplication.
- Reset mid-op: assert rst_n=0 asynchronously with S1 and S2 full -> rsp_valid=0 immediately. After release, ptr=0 and the first response belongs to the first post-reset request.
